rgb_pwm: RTL and testbench

Three-channel PWM output stage that sits directly downstream of the fade generator. It accepts R/G/B duty values over a valid/ready handshake and holds each accepted triple in a one-entry shadow buffer. It commits the triple to the active duty registers only at a PWM period boundary, so outputs never glitch mid-period. It drives the board RGB LED pins.

---
 rtl/rgb_pwm_pkg.sv | 22 ++
 rtl/rgb_pwm_channel.sv | 51 +++++
 rtl/rgb_pwm.sv | 129 ++++++++++++
 tb/tb_rgb_pwm.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pwm_pkg.sv
// rtl/rgb_pwm_pkg.sv - shared constants and types for the RGB PWM output stage
package rgb_pwm_pkg;

    localparam int PWM_INTERVAL_DEFAULT = 1200;
    localparam int W_DEFAULT            = $clog2(PWM_INTERVAL_DEFAULT);
    localparam int NUM_CH               = 3;

    typedef logic [W_DEFAULT-1:0] duty_t;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } chan_e;

    // One-entry shadow buffer occupancy
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/rgb_pwm_channel.sv
// rtl/rgb_pwm_channel.sv - one PWM channel: active duty, clamp/compare, registered pin
module pwm_channel
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_INTERVAL = PWM_INTERVAL_DEFAULT,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int W            = $clog2(PWM_INTERVAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] cnt,
    input  logic         load,
    input  logic [W-1:0] shadow_duty,
    output logic         pin
);

    // One extra bit so the interval itself is representable when it equals 2^W
    localparam logic [W:0] INTERVAL_EXT = (W+1)'(PWM_INTERVAL);

    logic [W-1:0] r_active;
    logic         r_pin;
    logic         w_clamp;
    logic         w_on;

    // Duties at or beyond the period length mean "on for the whole period"
    always_comb begin
        w_clamp = ({1'b0, r_active} >= INTERVAL_EXT);
        w_on    = w_clamp || (cnt < r_active);
    end

    // Active duty only changes at the period boundary, so no mid-period glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= '0;
        end else if (load) begin
            r_active <= shadow_duty;
        end
    end

    // Registered pin; polarity folded in here so the LED sees a clean edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pin <= ACTIVE_LOW;
        end else begin
            r_pin <= w_on ^ ACTIVE_LOW;
        end
    end

    assign pin = r_pin;

endmodule

// File: rtl/rgb_pwm.sv
// rtl/rgb_pwm.sv - three-channel PWM stage with shadowed duty triple committed at period wrap
module rgb_pwm
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_INTERVAL = PWM_INTERVAL_DEFAULT,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int W            = $clog2(PWM_INTERVAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] duty_r,
    input  logic [W-1:0] duty_g,
    input  logic [W-1:0] duty_b,
    input  logic         duty_valid,
    output logic         duty_ready,
    output logic         led_r,
    output logic         led_g,
    output logic         led_b,
    output logic         period_start
);

    localparam logic [W-1:0] CNT_LAST = W'(PWM_INTERVAL - 1);

    logic [W-1:0]       r_cnt;
    logic               r_period_start;
    buf_state_e         r_state;
    buf_state_e         w_state_next;
    logic               w_wrap;
    logic               w_accept;
    logic               w_load;
    logic [W-1:0]       w_duty_in [NUM_CH];
    logic [W-1:0]       r_shadow  [NUM_CH];
    logic [NUM_CH-1:0]  w_pin;

    assign w_wrap = (r_cnt == CNT_LAST);

    assign w_duty_in[CH_R] = duty_r;
    assign w_duty_in[CH_G] = duty_g;
    assign w_duty_in[CH_B] = duty_b;

    // Free-running period counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Shadow buffer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Shadow buffer next state: fill on handshake, drain into channels on wrap.
    // A triple captured on the wrap cycle itself waits for the following wrap.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            BUF_EMPTY: begin
                if (duty_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (w_wrap) begin
                    w_load       = 1'b1;
                    w_state_next = BUF_EMPTY;
                end
            end
            default: w_state_next = BUF_EMPTY;
        endcase
    end

    assign duty_ready = (r_state == BUF_EMPTY);

    // Capture the accepted triple into the shadow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_shadow[c] <= '0;
            end
        end else if (w_accept) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_shadow[c] <= w_duty_in[c];
            end
        end
    end

    // Pulse aligned with the first registered output of each period
    always_ff @(posedge clk) begin
        if (rst) begin
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= (r_cnt == '0);
        end
    end

    assign period_start = r_period_start;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pwm_channel #(
            .PWM_INTERVAL (PWM_INTERVAL),
            .ACTIVE_LOW   (ACTIVE_LOW),
            .W            (W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .cnt         (r_cnt),
            .load        (w_load),
            .shadow_duty (r_shadow[c]),
            .pin         (w_pin[c])
        );
    end

    assign led_r = w_pin[CH_R];
    assign led_g = w_pin[CH_G];
    assign led_b = w_pin[CH_B];

endmodule

// File: tb/tb_rgb_pwm.sv
// tb/tb_rgb_pwm.sv - self-checking bench for rgb_pwm
module tb_rgb_pwm;

    localparam int P = 12;
    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] duty_r;
    logic [W-1:0] duty_g;
    logic [W-1:0] duty_b;
    logic         duty_valid;
    logic         duty_ready;
    logic         led_r;
    logic         led_g;
    logic         led_b;
    logic         period_start;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] g;
        logic [W-1:0] b;
        int           lr;
        int           lg;
        int           lb;
    } vec_t;

    vec_t vecs [6];

    rgb_pwm #(
        .PWM_INTERVAL (P),
        .ACTIVE_LOW   (1'b1),
        .W            (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .duty_r       (duty_r),
        .duty_g       (duty_g),
        .duty_b       (duty_b),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .led_r        (led_r),
        .led_g        (led_g),
        .led_b        (led_b),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ps(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (period_start === 1'b1) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk({name, " period_start seen"}, 32'(found), 32'd1);
    endtask

    // Called on a period_start cycle; records one full period and compares the
    // pin patterns with "low for the first N cycles, high for the rest".
    task automatic measure(input string name, input int er, input int eg, input int eb);
        logic [P-1:0] pr, pg, pb, xr, xg, xb;
        logic [P-1:0] ps;
        for (int i = 0; i < P; i++) begin
            pr[i] = led_r;
            pg[i] = led_g;
            pb[i] = led_b;
            ps[i] = period_start;
            xr[i] = (i >= er);
            xg[i] = (i >= eg);
            xb[i] = (i >= eb);
            step();
        end
        chk({name, " led_r pattern"}, 32'(pr), 32'(xr));
        chk({name, " led_g pattern"}, 32'(pg), 32'(xg));
        chk({name, " led_b pattern"}, 32'(pb), 32'(xb));
        chk({name, " period_start pattern"}, 32'(ps), 32'h001);
    endtask

    initial begin
        int waited;

        // r=12 and r=14 both clamp to full-period on; r=11 leaves one high cycle
        vecs[0] = '{r: 4'd3,  g: 4'd6,  b: 4'd0,  lr: 3,  lg: 6,  lb: 0};
        vecs[1] = '{r: 4'd12, g: 4'd1,  b: 4'd2,  lr: 12, lg: 1,  lb: 2};
        vecs[2] = '{r: 4'd14, g: 4'd15, b: 4'd13, lr: 12, lg: 12, lb: 12};
        vecs[3] = '{r: 4'd11, g: 4'd5,  b: 4'd9,  lr: 11, lg: 5,  lb: 9};
        vecs[4] = '{r: 4'd0,  g: 4'd0,  b: 4'd0,  lr: 0,  lg: 0,  lb: 0};
        vecs[5] = '{r: 4'd1,  g: 4'd12, b: 4'd7,  lr: 1,  lg: 12, lb: 7};

        rst        = 1'b1;
        duty_valid = 1'b0;
        duty_r     = '0;
        duty_g     = '0;
        duty_b     = '0;
        @(negedge clk);
        repeat (3) step();
        chk("reset leds", {29'd0, led_r, led_g, led_b}, 32'h7);
        chk("reset duty_ready", 32'(duty_ready), 32'd1);
        chk("reset period_start", 32'(period_start), 32'd0);

        // First edge out of reset sees cnt==0, so the pulse follows it directly
        rst = 1'b0;
        for (int j = 0; j < 2 * P; j++) begin
            step();
            chk("idle leds", {29'd0, led_r, led_g, led_b}, 32'h7);
            chk("idle duty_ready", 32'(duty_ready), 32'd1);
            chk("idle period_start", 32'(period_start), 32'((j % P) == 0));
        end

        // Table: accept mid-period, expect the pattern in the next full period
        for (int v = 0; v < 6; v++) begin
            wait_ps("vec align");
            repeat (3) step();
            chk("vec ready before send", 32'(duty_ready), 32'd1);
            duty_r     = vecs[v].r;
            duty_g     = vecs[v].g;
            duty_b     = vecs[v].b;
            duty_valid = 1'b1;
            step();
            duty_valid = 1'b0;
            chk("vec ready after accept", 32'(duty_ready), 32'd0);
            wait_ps("vec commit");
            measure($sformatf("vec%0d", v), vecs[v].lr, vecs[v].lg, vecs[v].lb);
        end

        // Backpressure: A accepted at cnt 4, B held until the cycle after the wrap
        wait_ps("bp align");
        repeat (3) step();
        duty_r = 4'd2; duty_g = 4'd2; duty_b = 4'd2;
        duty_valid = 1'b1;
        step();
        duty_r = 4'd7; duty_g = 4'd7; duty_b = 4'd7;
        waited = 0;
        while (duty_ready !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        chk("bp ready-low cycles", 32'(waited), 32'd7);
        chk("bp ready rises before period_start", 32'(period_start), 32'd0);
        step();
        duty_valid = 1'b0;
        chk("bp B held off", 32'(duty_ready), 32'd0);
        measure("bp A", 2, 2, 2);
        measure("bp B", 7, 7, 7);

        // Wrap-coincident accept: handshake on the cnt==11 edge
        repeat (P - 2) step();
        chk("wrap ready", 32'(duty_ready), 32'd1);
        duty_r = 4'd5; duty_g = 4'd7; duty_b = 4'd7;
        duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        chk("wrap shadow full", 32'(duty_ready), 32'd0);
        chk("wrap no pulse yet", 32'(period_start), 32'd0);
        step();
        measure("wrap old", 7, 7, 7);
        measure("wrap new", 5, 7, 7);

        // Mid-run reset with a pending triple
        repeat (2) step();
        duty_r = 4'd1; duty_g = 4'd1; duty_b = 4'd1;
        duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        chk("mrst pending", 32'(duty_ready), 32'd0);
        rst = 1'b1;
        step();
        chk("mrst leds off", {29'd0, led_r, led_g, led_b}, 32'h7);
        chk("mrst duty_ready", 32'(duty_ready), 32'd1);
        step();
        rst = 1'b0;
        for (int j = 0; j < 3 * P; j++) begin
            step();
            chk("mrst discarded leds", {29'd0, led_r, led_g, led_b}, 32'h7);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
